gerador_serial: RTL

- Serial pattern transmitter: the other end of the run-of-ones serial detector interface.
- Accepts a parallel word plus a bit count, then drives it MSB-first on a single serial line `x`, one bit per `clk`.
- Produces a cycle-accurate expected-detect flag `exp_y` and a per-frame hit counter. Benches and top-level tests use these to drive and self-check the detector (`y` = 1 on the 4th and later consecutive 1s).

---
 rtl/gerador_serial_pkg.sv | 11 +
 rtl/gerador_serial_if.sv | 15 +
 rtl/registrador_deslocamento.sv | 16 +
 rtl/gerador_serial.sv | 58 +++++
 4 files changed

// File: rtl/gerador_serial_pkg.sv
// gerador_serial_pkg: shared state encoding, run limit and length helpers
package gerador_serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int RUN_MAX = 3;
  function automatic int len_width(int w);
    return $clog2(w + 1);
  endfunction
  function automatic int clamp_len(int l, int w);
    return (l > w) ? w : l;
  endfunction
endpackage

// File: rtl/gerador_serial_if.sv
// gerador_serial_if: frame request and serial/check outputs of the pattern transmitter
interface gerador_serial_if import gerador_serial_pkg::*; #(parameter int WIDTH = 8);
  localparam int LW = len_width(WIDTH);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [LW-1:0]    len;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             exp_y;
  logic             done;
  logic [7:0]       hit_count;
  modport master(output start, data, len, input ready, x, x_valid, exp_y, done, hit_count);
  modport slave(input start, data, len, output ready, x, x_valid, exp_y, done, hit_count);
endinterface

// File: rtl/registrador_deslocamento.sv
// registrador_deslocamento: load/shift-left register exposing its MSB
module registrador_deslocamento #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_msb
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (i_load) r_q <= i_d;
    else if (i_shift) r_q <= r_q << 1;
  assign o_msb = r_q[WIDTH-1];
endmodule

// File: rtl/gerador_serial.sv
// gerador_serial: MSB-first serial frame transmitter with expected run-of-ones detect flag
module gerador_serial import gerador_serial_pkg::*; #(parameter int WIDTH = 8) (
  input logic           clk,
  input logic           rst_n,
  gerador_serial_if.slave bus
);
  localparam int LW = len_width(WIDTH);
  state_t        r_state, w_next;
  logic [LW-1:0] r_cnt, w_lc;
  logic [1:0]    r_rc;
  logic [7:0]    r_hit;
  logic          r_x, r_xv, r_done, w_accept, w_shift, w_msb, w_y;
  assign w_lc     = LW'(clamp_len(int'(bus.len), WIDTH));
  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_shift  = (r_state == SHIFT);
  assign w_y      = r_x && (r_rc == 2'(RUN_MAX));
  // first bit goes straight to r_x, so the register holds the remaining bits
  registrador_deslocamento #(.WIDTH(WIDTH)) u_sr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_shift(w_shift),
    .i_d    (bus.data << 1),
    .o_msb  (w_msb)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? ((w_lc != '0) ? SHIFT : DONE) : IDLE;
      SHIFT:   w_next = (r_cnt == LW'(1)) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= 1'b0;
      r_xv    <= 1'b0;
      r_done  <= 1'b0;
      r_rc    <= '0;
      r_hit   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_accept ? w_lc : (w_shift ? r_cnt - LW'(1) : r_cnt);
      r_xv    <= (w_next == SHIFT);
      r_x     <= (w_next == SHIFT) && (w_accept ? bus.data[WIDTH-1] : w_msb);
      r_done  <= (w_next == DONE);
      r_rc    <= r_x ? ((r_rc == 2'(RUN_MAX)) ? r_rc : r_rc + 2'd1) : 2'd0;
      r_hit   <= w_accept ? '0 : ((w_y && r_hit != 8'hFF) ? r_hit + 8'd1 : r_hit);
    end
  assign bus.ready     = (r_state == IDLE);
  assign bus.x         = r_x;
  assign bus.x_valid   = r_xv;
  assign bus.exp_y     = w_y;
  assign bus.done      = r_done;
  assign bus.hit_count = r_hit;
endmodule
